// File: rtl/alu_mc.sv
// alu_mc: registered, multi-cycle ALU with valid/ready handshakes on both sides.
// Logic, add/sub, compares and shifts finish in one cycle. MULU, DIVU and REMU
// iterate one bit per cycle. DIVU/REMU by zero completes in a single cycle.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALU_OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic             ZF,
  output logic             OF,
  output logic             SF,
  output logic             CF,
  output logic             PF,
  output logic             DZ
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t           state_r;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] a_r;    // multiplicand (MULU) or dividend/quotient shifter (DIVU/REMU)
  logic [WIDTH-1:0] b_r;    // multiplier (MULU) or divisor (DIVU/REMU)
  logic [WIDTH:0]   acc_r;  // partial product (MULU) or partial remainder (DIVU/REMU)
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] f_r;
  logic             zf_r, of_r, sf_r, cf_r, pf_r, dz_r, out_valid_r;

  logic [WIDTH-1:0] sc_res_s;
  logic             sc_cf_s, sc_of_s, sc_dz_s;
  logic [WIDTH:0]   sum_s;
  logic [SHW-1:0]   shamt_s;
  logic             long_op_s;
  logic [WIDTH:0]   acc_nxt_s;
  logic [WIDTH-1:0] a_nxt_s, b_nxt_s, it_res_s;
  logic [WIDTH:0]   rem_sh_s;

  // Even parity of a result word: 1 when the number of set bits is even.
  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ~^v;
  endfunction

  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign F  = f_r;
  assign ZF = zf_r;
  assign OF = of_r;
  assign SF = sf_r;
  assign CF = cf_r;
  assign PF = pf_r;
  assign DZ = dz_r;
  assign shamt_s = A[SHW-1:0];

  // Single-cycle datapath plus the decision whether the incoming op must iterate.
  always_comb begin
    sc_res_s  = {WIDTH{1'b0}};
    sc_cf_s   = 1'b0;
    sc_of_s   = 1'b0;
    sc_dz_s   = 1'b0;
    sum_s     = {(WIDTH+1){1'b0}};
    long_op_s = 1'b0;
    case (ALU_OP)
      4'b0000: sc_res_s = A & B;
      4'b0001: sc_res_s = A | B;
      4'b0010: sc_res_s = A ^ B;
      4'b0011: sc_res_s = ~(A | B);
      4'b0100: begin
        sum_s    = {1'b0, A} + {1'b0, B};
        sc_res_s = sum_s[WIDTH-1:0];
        sc_cf_s  = sum_s[WIDTH];
        sc_of_s  = (A[WIDTH-1] == B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0101: begin
        sum_s    = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        sc_res_s = sum_s[WIDTH-1:0];
        sc_cf_s  = ~sum_s[WIDTH];  // no carry out means a borrow occurred
        sc_of_s  = (A[WIDTH-1] == ~B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0110: sc_res_s = {{(WIDTH-1){1'b0}}, (A < B)};
      4'b0111: sc_res_s = B << shamt_s;
      4'b1000: sc_res_s = B >> shamt_s;
      4'b1001: sc_res_s = $signed(B) >>> shamt_s;
      4'b1010: sc_res_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'b1011: long_op_s = 1'b1;
      4'b1100: begin
        if (B == {WIDTH{1'b0}}) begin
          sc_res_s = {WIDTH{1'b1}};
          sc_dz_s  = 1'b1;
        end else begin
          long_op_s = 1'b1;
        end
      end
      4'b1101: begin
        if (B == {WIDTH{1'b0}}) begin
          sc_res_s = A;
          sc_dz_s  = 1'b1;
        end else begin
          long_op_s = 1'b1;
        end
      end
      default: sc_res_s = {WIDTH{1'b0}};
    endcase
  end

  // One shift-add (MULU) or restoring shift-subtract (DIVU/REMU) step.
  always_comb begin
    rem_sh_s = {acc_r[WIDTH-1:0], a_r[WIDTH-1]};
    if (op_r == 4'b1011) begin
      acc_nxt_s = {1'b0, acc_r[WIDTH-1:0] + (b_r[0] ? a_r : {WIDTH{1'b0}})};
      a_nxt_s   = a_r << 1;
      b_nxt_s   = b_r >> 1;
    end else if (rem_sh_s >= {1'b0, b_r}) begin
      acc_nxt_s = rem_sh_s - {1'b0, b_r};
      a_nxt_s   = {a_r[WIDTH-2:0], 1'b1};
      b_nxt_s   = b_r;
    end else begin
      acc_nxt_s = rem_sh_s;
      a_nxt_s   = {a_r[WIDTH-2:0], 1'b0};
      b_nxt_s   = b_r;
    end
    if (op_r == 4'b1100) begin
      it_res_s = a_nxt_s;
    end else begin
      it_res_s = acc_nxt_s[WIDTH-1:0];
    end
  end

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      op_r        <= 4'b0000;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      acc_r       <= {(WIDTH+1){1'b0}};
      cnt_r       <= {CW{1'b0}};
      f_r         <= {WIDTH{1'b0}};
      zf_r        <= 1'b0;
      of_r        <= 1'b0;
      sf_r        <= 1'b0;
      cf_r        <= 1'b0;
      pf_r        <= 1'b0;
      dz_r        <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            op_r  <= ALU_OP;
            a_r   <= A;
            b_r   <= B;
            acc_r <= {(WIDTH+1){1'b0}};
            if (long_op_s) begin
              state_r <= CALC;
              cnt_r   <= CNT_LOAD;
            end else begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
              f_r         <= sc_res_s;
              zf_r        <= (sc_res_s == {WIDTH{1'b0}});
              sf_r        <= sc_res_s[WIDTH-1];
              pf_r        <= even_parity(sc_res_s);
              cf_r        <= sc_cf_s;
              of_r        <= sc_of_s;
              dz_r        <= sc_dz_s;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          acc_r <= acc_nxt_s;
          a_r   <= a_nxt_s;
          b_r   <= b_nxt_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            f_r         <= it_res_s;
            zf_r        <= (it_res_s == {WIDTH{1'b0}});
            sf_r        <= it_res_s[WIDTH-1];
            pf_r        <= even_parity(it_res_s);
            cf_r        <= 1'b0;
            of_r        <= 1'b0;
            dz_r        <= 1'b0;
          end else begin
            state_r <= CALC;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed cases plus randomized ops against
// an arithmetic reference model.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  alu_op;
  logic [31:0] a, b, f;
  logic        zf, of, sf, cf, pf, dz;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] f;
    logic zf, of, sf, cf, pf, dz;
  } res_t;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALU_OP(alu_op), .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready),
    .F(f), .ZF(zf), .OF(of), .SF(sf), .CF(cf), .PF(pf), .DZ(dz)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    res_t r;
    longint sx, sy, s;
    logic [63:0] w;
    int sh;
    r = '0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(x % 32);
    case (op)
      4'd0: r.f = x & y;
      4'd1: r.f = x | y;
      4'd2: r.f = x ^ y;
      4'd3: r.f = ~(x | y);
      4'd4: begin
        w = {32'd0, x} + {32'd0, y};
        r.f = w[31:0];
        r.cf = (w > 64'hFFFF_FFFF);
        s = sx + sy;
        r.of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd5: begin
        r.f = x - y;
        r.cf = (x < y);
        s = sx - sy;
        r.of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd6: r.f = (x < y) ? 32'd1 : 32'd0;
      4'd7: r.f = y << sh;
      4'd8: r.f = y >> sh;
      4'd9: begin
        w = sy >>> sh;
        r.f = w[31:0];
      end
      4'd10: r.f = (sx < sy) ? 32'd1 : 32'd0;
      4'd11: begin
        w = {32'd0, x} * {32'd0, y};
        r.f = w[31:0];
      end
      4'd12: begin
        if (y == 32'd0) begin r.f = 32'hFFFF_FFFF; r.dz = 1'b1; end
        else r.f = x / y;
      end
      4'd13: begin
        if (y == 32'd0) begin r.f = x; r.dz = 1'b1; end
        else r.f = x % y;
      end
      default: r.f = 32'd0;
    endcase
    r.zf = (r.f == 32'd0);
    r.sf = r.f[31];
    r.pf = ($countones(r.f) % 2) == 0;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op at #1 after an edge, wait for the result, hold it, then retire it.
  task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input int hold, output logic [31:0] fo);
    res_t e;
    int lat, exp_lat;
    e = model(op, x, y);
    exp_lat = (op == 4'd11 || ((op == 4'd12 || op == 4'd13) && y != 32'd0)) ? 33 : 1;
    check("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1; alu_op = op; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0; alu_op = 4'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("result_F", 64'(f), 64'(e.f));
    check("flags", 64'({zf, of, sf, cf, pf, dz}), 64'({e.zf, e.of, e.sf, e.cf, e.pf, e.dz}));
    fo = f;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_F", 64'(f), 64'(e.f));
      check("hold_busy", 64'({out_valid, in_ready}), 64'(2'b10));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("retired", 64'({out_valid, in_ready}), 64'(2'b01));
  endtask

  initial begin
    logic [31:0] r;
    logic [3:0]  op;
    logic [31:0] x, y;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 4'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'({out_valid, f, zf, of, sf, cf, pf, dz}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // Reset during a MULU discards it.
    in_valid = 1'b1; alu_op = 4'b1011; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mulu_busy", 64'(in_ready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midop_reset", 64'({out_valid, f}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("after_reset_ready", 64'({in_ready, out_valid}), 64'(2'b10));
    @(posedge clk); #1;
    do_op(4'b0100, 32'd1, 32'd1, 0, r);
    check("fresh_add", 64'(r), 64'd2);

    // Directed boundary cases.
    do_op(4'b0100, 32'h7FFF_FFFF, 32'd1, 1, r);
    check("add_ovf_F", 64'(r), 64'h8000_0000);
    do_op(4'b0101, 32'd5, 32'd5, 0, r);
    check("sub_zero_F", 64'(r), 64'd0);
    do_op(4'b0101, 32'd3, 32'd5, 0, r);
    check("sub_borrow_F", 64'(r), 64'hFFFF_FFFE);
    do_op(4'b1011, 32'h0001_0001, 32'h0001_0001, 5, r);
    check("mulu_F", 64'(r), 64'h0002_0001);
    do_op(4'b1100, 32'd100, 32'd7, 0, r);
    check("divu_F", 64'(r), 64'd14);
    do_op(4'b1101, 32'd100, 32'd7, 0, r);
    check("remu_F", 64'(r), 64'd2);
    do_op(4'b1100, 32'd100, 32'd0, 0, r);
    check("divz_F", 64'(r), 64'hFFFF_FFFF);
    do_op(4'b1101, 32'd100, 32'd0, 0, r);
    do_op(4'b1001, 32'd4, 32'h8000_0000, 0, r);
    check("sra_F", 64'(r), 64'hF800_0000);
    do_op(4'b1000, 32'd4, 32'h8000_0000, 0, r);
    check("srl_F", 64'(r), 64'h0800_0000);
    do_op(4'b1010, 32'hFFFF_FFFF, 32'd1, 0, r);
    check("slt_F", 64'(r), 64'd1);
    do_op(4'b0110, 32'hFFFF_FFFF, 32'd1, 0, r);
    check("sltu_F", 64'(r), 64'd0);
    do_op(4'b1110, 32'h1234_5678, 32'h9ABC_DEF0, 0, r);
    do_op(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, r);

    // Randomized ops against the reference model.
    for (int k = 0; k < 48; k++) begin
      op = 4'($urandom_range(0, 15));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 5) == 0) y = 32'd0;
      else if ($urandom_range(0, 1) == 1) y = y >> $urandom_range(0, 31);
      do_op(op, x, y, $urandom_range(0, 2), r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
